// File: rtl/ucaspian_pkg.sv
// Shared widths, synapse FSM states and config byte codes for the uCaspian synapse stage.
package ucaspian_pkg;
  localparam int SYN_AW    = 12;
  localparam int NEURON_AW = 8;
  localparam int WEIGHT_W  = 8;
  localparam int SYN_DW    = NEURON_AW + WEIGHT_W;
  localparam int SYN_DEPTH = 1 << SYN_AW;

  localparam logic [2:0] CFG_SYN_TGT = 3'd4;
  localparam logic [2:0] CFG_SYN_WR  = 3'd5;

  typedef enum logic [1:0] {
    SYN_IDLE,
    SYN_FETCH,
    SYN_SEND
  } syn_state_e;
endpackage

// File: rtl/ucaspian_syn_ram.sv
// Single-port synapse RAM, {target, weight} per entry; read-first with registered output.
module ucaspian_syn_ram
  import ucaspian_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [SYN_AW-1:0] addr,
  input  logic [SYN_DW-1:0] wdata,
  output logic [SYN_DW-1:0] rdata
);
  logic [SYN_DW-1:0] mem [0:SYN_DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/ucaspian_synapse.sv
// Walks an accepted synapse range through the synapse RAM and streams one
// (target neuron, signed weight) fire per entry to the dendrite stage.
module ucaspian_synapse
  import ucaspian_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear_act,
  input  logic                       clear_config,
  output logic                       clear_done,
  input  logic [SYN_AW-1:0]          config_addr,
  input  logic [7:0]                 config_value,
  input  logic [2:0]                 config_byte,
  input  logic                       config_enable,
  input  logic                       next_step,
  output logic                       step_done,
  input  logic [SYN_AW-1:0]          syn_start,
  input  logic [SYN_AW-1:0]          syn_end,
  input  logic                       syn_vld,
  output logic                       syn_rdy,
  output logic [NEURON_AW-1:0]       dend_addr,
  output logic signed [WEIGHT_W-1:0] dend_weight,
  output logic                       dend_vld,
  input  logic                       dend_rdy
);
  syn_state_e          state;
  logic [SYN_AW-1:0]   cur_p0, end_p0, clr_cnt;
  logic                clr_full;
  logic [NEURON_AW-1:0] tgt_latch;
  logic                clr_any, run, syn_hs, dend_hs, last, adv, cfg_wr;
  logic                ram_we;
  logic [SYN_AW-1:0]   ram_addr;
  logic [SYN_DW-1:0]   ram_wdata, rd_data_p1;
  logic                unused_next_step;

  assign unused_next_step = next_step;

  assign clr_any = clear_act || clear_config;
  assign run     = enable && !clr_any;
  assign syn_hs  = run && (state == SYN_IDLE) && syn_vld && syn_rdy;
  assign dend_hs = run && (state == SYN_SEND) && dend_vld && dend_rdy;
  assign last    = (cur_p0 == end_p0);
  assign adv     = dend_hs && !last;
  // A write landing in the same cycle as a range accept would steal the read port.
  assign cfg_wr  = !clear_config && config_enable && (config_byte == CFG_SYN_WR)
                   && (state == SYN_IDLE) && !syn_hs;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = cur_p0;
    ram_wdata = '0;
    if (clear_config) begin
      ram_we   = !clr_full;
      ram_addr = clr_cnt;
    end else if (syn_hs) begin
      ram_addr = syn_start;
    end else if (cfg_wr) begin
      ram_we    = 1'b1;
      ram_addr  = config_addr;
      ram_wdata = {tgt_latch, config_value};
    end else if (adv) begin
      ram_addr = cur_p0 + 1'b1;
    end
  end

  ucaspian_syn_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (rd_data_p1)
  );

  always_ff @(posedge clk) begin
    if (!clear_config && config_enable && (config_byte == CFG_SYN_TGT))
      tgt_latch <= config_value;
  end

  // Stage p0: range cursor; the RAM read of cur+1 is issued in the same cycle as the increment.
  always_ff @(posedge clk) begin
    if (syn_hs) begin
      cur_p0 <= syn_start;
      end_p0 <= syn_end;
    end else if (adv) begin
      cur_p0 <= cur_p0 + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYN_IDLE;
      syn_rdy    <= 1'b0;
      dend_vld   <= 1'b0;
      step_done  <= 1'b0;
      clear_done <= 1'b0;
      clr_cnt    <= '0;
      clr_full   <= 1'b0;
    end else begin
      if (clear_config) begin
        if (!clr_full) clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == '1) clr_full <= 1'b1;
        clear_done <= clr_full || (clr_cnt == '1);
      end else begin
        clr_cnt    <= '0;
        clr_full   <= 1'b0;
        clear_done <= clear_act;
      end

      if (clr_any) begin
        state     <= SYN_IDLE;
        syn_rdy   <= 1'b0;
        dend_vld  <= 1'b0;
        step_done <= 1'b0;
      end else if (enable) begin
        step_done <= (state == SYN_IDLE) && !syn_hs;
        case (state)
          SYN_IDLE: begin
            syn_rdy <= !syn_hs;
            if (syn_hs) state <= SYN_FETCH;
          end
          SYN_FETCH: begin
            dend_vld <= 1'b1;
            state    <= SYN_SEND;
          end
          SYN_SEND: begin
            if (dend_hs && last) begin
              dend_vld <= 1'b0;
              syn_rdy  <= 1'b1;
              state    <= SYN_IDLE;
            end
          end
          default: state <= SYN_IDLE;
        endcase
      end
    end
  end

  // Stage p1: the RAM output register is the fire payload; while held, the read re-fetches cur.
  assign dend_addr   = dend_vld ? rd_data_p1[SYN_DW-1:WEIGHT_W] : '0;
  assign dend_weight = dend_vld ? $signed(rd_data_p1[WEIGHT_W-1:0]) : '0;
endmodule

// File: tb/tb_ucaspian_synapse.sv
// Bench for ucaspian_synapse: hand sequences, a range table and random ranges against a RAM model.
module tb_ucaspian_synapse;
  import ucaspian_pkg::*;

  typedef struct {
    logic [11:0] s;
    logic [11:0] e;
    bit          rnd_rdy;
    int          exp_n;
  } range_vec_t;

  logic              clk = 1'b0;
  logic              reset, enable, clear_act, clear_config, clear_done;
  logic [11:0]       config_addr;
  logic [7:0]        config_value;
  logic [2:0]        config_byte;
  logic              config_enable, next_step, step_done;
  logic [11:0]       syn_start, syn_end;
  logic              syn_vld, syn_rdy;
  logic [7:0]        dend_addr;
  logic signed [7:0] dend_weight;
  logic              dend_vld, dend_rdy;

  int checks = 0;
  int passes = 0;
  logic [15:0] mem_m [0:4095];
  range_vec_t vecs [6];

  always #5 clk = ~clk;

  ucaspian_synapse dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .clear_act     (clear_act),
    .clear_config  (clear_config),
    .clear_done    (clear_done),
    .config_addr   (config_addr),
    .config_value  (config_value),
    .config_byte   (config_byte),
    .config_enable (config_enable),
    .next_step     (next_step),
    .step_done     (step_done),
    .syn_start     (syn_start),
    .syn_end       (syn_end),
    .syn_vld       (syn_vld),
    .syn_rdy       (syn_rdy),
    .dend_addr     (dend_addr),
    .dend_weight   (dend_weight),
    .dend_vld      (dend_vld),
    .dend_rdy      (dend_rdy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cfg_write(input logic [11:0] a, input logic [7:0] tgt, input logic [7:0] w);
    config_enable = 1'b1;
    config_byte   = CFG_SYN_TGT;
    config_value  = tgt;
    tick();
    config_byte   = CFG_SYN_WR;
    config_value  = w;
    config_addr   = a;
    tick();
    config_enable = 1'b0;
    config_byte   = 3'd0;
    mem_m[a]      = {tgt, w};
  endtask

  // Sends one range and consumes fires until dend_vld drops, comparing each against the model.
  task automatic run_range(input logic [11:0] s, input logic [11:0] e, input bit rnd, output int n);
    logic [11:0] idx;
    logic [15:0] held;
    bit holding, seen;
    int guard, lat;
    n = 0; idx = s; holding = 0; seen = 0; lat = 0; guard = 0;
    syn_start = s; syn_end = e; syn_vld = 1'b1; dend_rdy = 1'b0;
    while (!syn_rdy && guard < 50) begin tick(); guard++; end
    check("syn_rdy_before_accept", syn_rdy, 1);
    tick();
    syn_vld = 1'b0;
    check("accept_drops_rdy", syn_rdy, 0);
    guard = 0;
    while (guard < 20000) begin
      if (dend_vld && !seen) begin
        seen = 1;
        check("first_vld_latency", lat, 1);
      end
      if (seen && !dend_vld) break;
      dend_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (dend_vld) begin
        if (holding) check("hold_stable", {dend_addr, dend_weight}, held);
        check("step_done_busy", step_done, 0);
        if (dend_rdy) begin
          check($sformatf("fire_idx%0d", idx), {dend_addr, dend_weight}, mem_m[idx]);
          n++;
          idx++;
          holding = 0;
        end else begin
          holding = 1;
          held = {dend_addr, dend_weight};
        end
      end
      tick();
      lat++;
      guard++;
    end
    if (guard >= 20000) check("range_timeout", 0, 1);
    dend_rdy = 1'b0;
    check("rdy_after_range", syn_rdy, 1);
    check("step_done_lag", step_done, 0);
    tick();
    check("step_done_idle", step_done, 1);
  endtask

  initial begin
    int n, cyc;
    reset = 1'b1; enable = 1'b1; clear_act = 1'b0; clear_config = 1'b0;
    config_addr = '0; config_value = '0; config_byte = '0; config_enable = 1'b0;
    next_step = 1'b0; syn_start = '0; syn_end = '0; syn_vld = 1'b0; dend_rdy = 1'b0;
    repeat (3) tick();
    check("rst_syn_rdy", syn_rdy, 0);
    check("rst_out", {dend_vld, dend_addr, dend_weight}, 0);
    check("rst_flags", {step_done, clear_done}, 0);
    reset = 1'b0;
    tick();
    check("idle_syn_rdy", syn_rdy, 1);
    check("idle_step_done", step_done, 1);

    // Zero the RAM so the model starts from known contents.
    clear_config = 1'b1;
    cyc = 0;
    while (!clear_done && cyc < 5000) begin tick(); cyc++; end
    check("init_clear_cycles", cyc, 4096);
    clear_config = 1'b0;
    for (int i = 0; i < 4096; i++) mem_m[i] = 16'h0000;
    tick();
    check("clear_done_release", clear_done, 0);

    // Two-entry range at full throughput.
    cfg_write(12'd10, 8'd3, 8'h05);
    cfg_write(12'd11, 8'd7, 8'hFE);
    syn_start = 12'd10; syn_end = 12'd11; syn_vld = 1'b1; dend_rdy = 1'b1;
    tick();
    syn_vld = 1'b0;
    check("hs1_fetch_vld", dend_vld, 0);
    check("hs1_rdy_low", syn_rdy, 0);
    tick();
    check("hs1_fire0", {dend_vld, dend_addr, dend_weight}, 17'h10305);
    tick();
    check("hs1_fire1", {dend_vld, dend_addr, dend_weight}, 17'h107FE);
    tick();
    check("hs1_vld_drop", dend_vld, 0);
    check("hs1_rdy_back", syn_rdy, 1);

    // Backpressure with a dropped config write and an enable pause while held.
    dend_rdy = 1'b0; syn_vld = 1'b1;
    tick();
    syn_vld = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bp_hold%0d", c), {dend_vld, dend_addr, dend_weight}, 17'h10305);
      if (c == 0) begin config_enable = 1'b1; config_byte = CFG_SYN_TGT; config_value = 8'd9; end
      if (c == 1) begin config_byte = CFG_SYN_WR; config_value = 8'h33; config_addr = 12'd11; end
      if (c == 2) begin config_enable = 1'b0; config_byte = 3'd0; enable = 1'b0; end
      if (c == 3) begin enable = 1'b1; dend_rdy = 1'b1; end
      tick();
    end
    check("bp_fire1", {dend_vld, dend_addr, dend_weight}, 17'h107FE);
    tick();
    check("bp_vld_drop", dend_vld, 0);
    dend_rdy = 1'b0;
    tick();

    // Range table: wrap, single entry, weight-0 entries, random backpressure.
    cfg_write(12'd4094, 8'd40, 8'h11);
    cfg_write(12'd4095, 8'd41, 8'h22);
    cfg_write(12'd0,    8'd42, 8'hF0);
    cfg_write(12'd1,    8'd43, 8'h00);
    cfg_write(12'd200,  8'd99, 8'h80);
    for (int k = 300; k < 332; k++) cfg_write(12'(k), 8'($urandom), 8'($urandom));
    vecs[0] = '{12'd10,   12'd11,  1'b0, 2};
    vecs[1] = '{12'd4094, 12'd1,   1'b0, 4};
    vecs[2] = '{12'd200,  12'd200, 1'b0, 1};
    vecs[3] = '{12'd4094, 12'd1,   1'b1, 4};
    vecs[4] = '{12'd300,  12'd331, 1'b1, 32};
    vecs[5] = '{12'd4090, 12'd3,   1'b1, 10};
    for (int i = 0; i < 6; i++) begin
      run_range(vecs[i].s, vecs[i].e, vecs[i].rnd_rdy, n);
      check($sformatf("table%0d_count", i), n, vecs[i].exp_n);
    end

    // Random ranges over randomly reconfigured entries.
    for (int it = 0; it < 20; it++) begin
      logic [11:0] s, e;
      int len;
      s = (it % 4 == 0) ? 12'(4090 + $urandom_range(0, 5)) : 12'($urandom_range(0, 4095));
      len = $urandom_range(1, 24);
      e = 12'(s + 12'(len - 1));
      for (int k = 0; k < len; k++)
        if ($urandom_range(0, 1) == 1) cfg_write(12'(s + 12'(k)), 8'($urandom), 8'($urandom));
      run_range(s, e, 1'b1, n);
      check("rand_count", n, len);
    end

    // Abort mid-range after three fires.
    syn_start = 12'd10; syn_end = 12'd20; syn_vld = 1'b1; dend_rdy = 1'b1;
    tick();
    syn_vld = 1'b0;
    repeat (4) tick();
    check("abort_pre", {dend_vld, dend_addr, dend_weight}, {1'b1, mem_m[13]});
    clear_act = 1'b1; dend_rdy = 1'b0;
    tick();
    check("abort_vld", dend_vld, 0);
    check("abort_clear_done", clear_done, 1);
    check("abort_syn_rdy", syn_rdy, 0);
    clear_act = 1'b0;
    tick();
    check("abort_release_done", clear_done, 0);
    run_range(12'd10, 12'd11, 1'b0, n);
    check("after_abort_count", n, 2);

    // Full clear racing a range handshake and a config write.
    syn_start = 12'd10; syn_end = 12'd11; syn_vld = 1'b1; clear_config = 1'b1;
    tick();
    syn_vld = 1'b0;
    for (int k = 1; k < 4095; k++) begin
      if (k == 100) begin config_enable = 1'b1; config_byte = CFG_SYN_TGT; config_value = 8'd5; end
      if (k == 101) begin config_byte = CFG_SYN_WR; config_value = 8'h44; config_addr = 12'd10; end
      if (k == 102) begin config_enable = 1'b0; config_byte = 3'd0; end
      tick();
    end
    check("clear_syn_rdy", syn_rdy, 0);
    check("clear_done_early", clear_done, 0);
    tick();
    check("clear_done_4096", clear_done, 1);
    repeat (2) tick();
    check("clear_done_held", clear_done, 1);
    clear_config = 1'b0;
    for (int i = 0; i < 4096; i++) mem_m[i] = 16'h0000;
    tick();
    check("clear_done_drop", clear_done, 0);
    tick();
    check("dropped_range", dend_vld, 0);
    run_range(12'd10, 12'd11, 1'b0, n);
    check("zeroed_count", n, 2);

    // Async reset in the middle of a held fire.
    cfg_write(12'd10, 8'd3, 8'h05);
    syn_start = 12'd10; syn_end = 12'd20; syn_vld = 1'b1; dend_rdy = 1'b0;
    tick();
    syn_vld = 1'b0;
    tick();
    check("pre_reset_vld", {dend_vld, dend_addr, dend_weight}, 17'h10305);
    #2 reset = 1'b1;
    #1;
    check("async_reset_out", {dend_vld, dend_addr, dend_weight}, 0);
    check("async_reset_ctl", {syn_rdy, step_done, clear_done}, 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_rdy", syn_rdy, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ucaspian_synapse.md
Name: ucaspian_synapse

Overview:
Responder end of the axon->synapse interface. It accepts one synapse range (start/end index) per handshake. It walks the range through a 4096-entry synapse RAM and emits one (target neuron, signed weight) fire per synapse to the dendrite/neuron input stage. It sits between ucaspian_axon and the neuron accumulate stage, and is configured through the shared config bus.

Parameters:
SYN_AW, 12, synapse index width (4096 entries)
NEURON_AW, 8, target neuron address width
WEIGHT_W, 8, signed weight width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
enable  in  1  run enable; FSM holds state when low
clear_act  in  1  abort in-flight activity
clear_config  in  1  zero synapse RAM (level, held until clear_done)
clear_done  out  1  clear complete
config_addr  in  12  synapse index for config write
config_value  in  8  config byte
config_byte  in  3  byte select
config_enable  in  1  config strobe
next_step  in  1  time-step boundary (informational; no state change)
step_done  out  1  no range pending or in flight
syn_start  in  12  first synapse index
syn_end  in  12  last synapse index (inclusive)
syn_vld  in  1  range valid
syn_rdy  out  1  ready to accept range
dend_addr  out  8  target neuron
dend_weight  out  8  signed weight (two's complement)
dend_vld  out  1  fire valid
dend_rdy  in  1  downstream ready

Behaviour:
- Reset (async): state=IDLE; syn_rdy=0, dend_vld=0, dend_addr=0, dend_weight=0, step_done=0, clear_done=0; clear counter=0. RAM contents are not reset.
- RAM entry [15:8] = target neuron, [7:0] = weight. Synchronous read, 1-cycle latency.
- Config:
  - config_byte=4 latches config_value as the target byte.
  - config_byte=5 writes {latched target, config_value} to config_addr.
  - Other byte values are ignored.
  - Config writes are accepted only when state=IDLE; otherwise they are dropped.
- Handshakes are valid/ready; a transfer occurs in any cycle with vld&&rdy. Once asserted, dend_vld holds, with data stable, until accepted.
- FSM:
  - IDLE: syn_rdy=1. On syn_vld&&syn_rdy: latch end, set cur=start, read RAM[start], drop syn_rdy -> FETCH.
  - FETCH: RAM data registers into dend_addr/dend_weight; dend_vld=1 -> SEND.
  - SEND, on dend handshake:
    - If cur==end: dend_vld=0 -> IDLE; syn_rdy is high the next cycle.
    - Else: cur=cur+1 and read RAM[cur+1] in the same cycle. Next-cycle data loads directly, so dend_vld stays 1 with no bubble.
  - SEND with no handshake: hold data; the RAM read address stays at cur.
- Throughput: 1 fire/cycle with dend_rdy=1. Latency from range accept to first dend_vld is 2 cycles.
- Range arithmetic: cur increments mod 4096.
  - end<start is a wrapping range (e.g. 4094..1 = 4 fires).
  - start==end gives 1 fire.
- Weight 0 is still emitted; no filtering.
- enable=0: all registers hold. Outputs stay asserted, but no handshake completes because syn_rdy and dend_vld are frozen. The bench must keep dend_rdy low during this time.
- step_done is registered: 1 when state=IDLE and no syn handshake is occurring this cycle; otherwise 0.
- clear_act (priority over enable): state->IDLE, dend_vld=0, syn_rdy=0 while asserted; clear_done=1 the next cycle.
- clear_config: FSM is forced the same way as clear_act.
  - A counter writes 0 to RAM[0..4095], one per cycle.
  - clear_done rises the cycle after index 4095 is written and stays high while clear_config is held.
  - Deassertion resets the counter and clear_done.
  - clear_config beats config_enable.
- Simultaneous clear and range handshake: clear wins; the range is dropped.

Decomposition:
- ucaspian_pkg holds:
  - SYN_AW, NEURON_AW, WEIGHT_W
  - state enum {SYN_IDLE, SYN_FETCH, SYN_SEND}
  - config byte codes CFG_SYN_TGT=4, CFG_SYN_WR=5
- One sub-module, ucaspian_syn_ram: 4096x16 single-port sync RAM with write enable, inferred as BRAM.

Test Plan:
- Config writes: RAM[10]={n=3,w=+5}, RAM[11]={n=7,w=-2}. Send range 10..11 with dend_rdy=1 -> fires (3,0x05),(7,0xFE) on consecutive cycles; first dend_vld 2 cycles after accept; syn_rdy high the cycle after the second fire.
- Backpressure: range 10..11 with dend_rdy low 3 cycles then high -> fire (3,0x05) held stable 4 cycles, then (7,0xFE); no duplicates or losses.
- Wrap: RAM[4094..4095,0,1] loaded with distinct targets, range 4094..1 -> exactly 4 fires in index order.
- Single entry: range 200..200 -> 1 fire; step_done low during, high 2 cycles after the fire.
- clear_act asserted mid-range 10..20 after 3 fires -> dend_vld=0 next cycle, clear_done=1. After release, a new range is accepted.
- clear_config held -> clear_done rises after 4096 writes. Range 10..11 then yields (0,0x00) twice. An async reset pulse mid-range drops all outputs to 0 immediately.
